// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter and its priority encoder.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: picks the first set request at or after ptr, wrapping modulo 8.
module rr_prio_enc8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  id,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  k;
    logic [ID_W-1:0]  idx;

    always_comb begin
        rot = '0;
        k   = '0;
        idx = '0;
        // 3-bit index arithmetic wraps naturally, so rot[i] is req[(ptr+i) mod 8]
        for (int i = 0; i < N_REQ; i++) begin
            idx    = ID_W'(i) + ptr;
            rot[i] = req[idx];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = ID_W'(i);
            end
        end
        id    = ptr + k;
        found = |req;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with one-hot and binary grant outputs and an optional hold limit.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam int unsigned     HC_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_ONE = HC_W'(MAX_HOLD != 0);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [ID_W-1:0]  arb_ptr;
    logic [ID_W-1:0]  arb_id;
    logic             arb_found;
    logic             hold_expired;
    logic             release_c;

    // While busy the encoder already sees the post-release pointer, so a handoff costs no bubble.
    assign arb_ptr = (state_q == BUSY) ? gnt_id_q + 1'b1 : ptr_q;

    rr_prio_enc8 u_enc (
        .req   (req),
        .ptr   (arb_ptr),
        .id    (arb_id),
        .found (arb_found)
    );

    always_comb begin
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);
        release_c    = (state_q == BUSY) && (done || !req[gnt_id_q] || hold_expired);

        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_id_d   = gnt_id_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;

        if (state_q == IDLE || release_c) begin
            if (release_c) begin
                ptr_d = arb_ptr;
            end
            if (arb_found) begin
                state_d    = BUSY;
                gnt_id_d   = arb_id;
                gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << arb_id;
                hold_cnt_d = HOLD_ONE;
            end else begin
                state_d    = IDLE;
                gnt_id_d   = '0;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q < HOLD_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_id_q   <= '0;
            gnt_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_id_q   <= gnt_id_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 built with a hold limit of 4 cycles.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; done = 1'b0;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b0, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values: got v=%0b id=%0d gnt=%h, want v=0 id=0 gnt=00", gnt_valid, gnt_id, gnt);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd0, 8'h01}) begin
            n_fail++;
            $display("FAIL reset_first_grant: got v=%0b id=%0d gnt=%h, want v=1 id=0 gnt=01", gnt_valid, gnt_id, gnt);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_id;
        logic [7:0] exp_gnt;
        // Owner 0 holds at entry; done every cycle walks the pointer round once.
        req = 8'hFF; done = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_id  = 3'(i % 8);
            exp_gnt = 8'h01 << exp_id;
            n_tests++;
            if ({gnt_valid, gnt_id, gnt} !== {1'b1, exp_id, exp_gnt}) begin
                n_fail++;
                $display("FAIL rotation_step%0d: got v=%0b id=%0d gnt=%h, want v=1 id=%0d gnt=%h",
                         i, gnt_valid, gnt_id, gnt, exp_id, exp_gnt);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_fairness_wrap();
        logic [2:0] exp_seq [3] = '{3'd0, 3'd5, 3'd0};
        do_reset();
        req = 8'h20;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id} !== {1'b1, 3'd5}) begin
            n_fail++;
            $display("FAIL wrap_setup: got v=%0b id=%0d, want v=1 id=5", gnt_valid, gnt_id);
        end
        req = 8'h21; done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({gnt_valid, gnt_id, gnt} !== {1'b1, exp_seq[i], 8'h01 << exp_seq[i]}) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got v=%0b id=%0d gnt=%h, want v=1 id=%0d",
                         i, gnt_valid, gnt_id, gnt, exp_seq[i]);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_hold_limit();
        logic [2:0] exp_id;
        do_reset();
        req = 8'h0C;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_id = (i >= 4 && i < 8) ? 3'd3 : 3'd2;
            n_tests++;
            if ({gnt_valid, gnt_id, gnt} !== {1'b1, exp_id, 8'h01 << exp_id}) begin
                n_fail++;
                $display("FAIL hold_pair_cyc%0d: got v=%0b id=%0d gnt=%h, want v=1 id=%0d",
                         i, gnt_valid, gnt_id, gnt, exp_id);
            end
        end
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_tests++;
            if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd2, 8'h04}) begin
                n_fail++;
                $display("FAIL hold_alone_cyc%0d: got v=%0b id=%0d gnt=%h, want v=1 id=2 gnt=04",
                         i, gnt_valid, gnt_id, gnt);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 8'h08;
        tick();
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd3, 8'h08}) begin
            n_fail++;
            $display("FAIL drop_owner3: got v=%0b id=%0d gnt=%h, want v=1 id=3 gnt=08", gnt_valid, gnt_id, gnt);
        end
        req = 8'h00;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b0, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL drop_idle: got v=%0b id=%0d gnt=%h, want v=0 id=0 gnt=00", gnt_valid, gnt_id, gnt);
        end
        // done while idle must not block a fresh grant
        req = 8'h80; done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd7, 8'h80}) begin
            n_fail++;
            $display("FAIL drop_regrant7: got v=%0b id=%0d gnt=%h, want v=1 id=7 gnt=80", gnt_valid, gnt_id, gnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'h01;
        tick();
        // Owner 0 releases: pointer moves to 1, so requester 5 wins over 0.
        req = 8'h21; done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd5, 8'h20}) begin
            n_fail++;
            $display("FAIL midrst_owner5: got v=%0b id=%0d gnt=%h, want v=1 id=5 gnt=20", gnt_valid, gnt_id, gnt);
        end
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b0, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_values: got v=%0b id=%0d gnt=%h, want v=0 id=0 gnt=00", gnt_valid, gnt_id, gnt);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({gnt_valid, gnt_id, gnt} !== {1'b1, 3'd0, 8'h01}) begin
            n_fail++;
            $display("FAIL midrst_ptr_cleared: got v=%0b id=%0d gnt=%h, want v=1 id=0 gnt=01", gnt_valid, gnt_id, gnt);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_rotation();
        test_fairness_wrap();
        test_hold_limit();
        test_req_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
